// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: Moore-decoded strobes, mem_ready stalls with timeout,
// retired-instruction counter. Define MCC_IMM_EN to add the addi/andi (IMMEX/IMMWB) path.
module multicycle_control #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUop,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_retired
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_RWB     = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_JUMP    = 4'd9;
  localparam logic [3:0] S_IMMEX   = 4'd10;
  localparam logic [3:0] S_IMMWB   = 4'd11;
  localparam logic [3:0] S_ILLEGAL = 4'd12;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;

  // Wide enough to hold MEM_TIMEOUT-1, the last count before abort.
  localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [3:0]       state_reg, state_next;
  logic [WC_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [5:0]       op_q_reg;
  logic [CNT_W-1:0] retired_reg;
  logic             waiting, timeout, retire;

  assign state         = state_reg;
  assign instr_retired = retired_reg;

  always_comb begin
    waiting = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);
    timeout = waiting && !mem_ready && (wait_cnt_reg == WC_W'(MEM_TIMEOUT - 1));
    state_next = S_FETCH;
    retire     = 1'b0;
    case (state_reg)
      S_FETCH:  state_next = mem_ready ? S_DECODE : (timeout ? S_FETCH : S_FETCH);
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
`ifdef MCC_IMM_EN
          OP_ADDI, OP_ANDI: state_next = S_IMMEX;
`endif
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_next = (op_q_reg == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = mem_ready ? S_MEMWB : (timeout ? S_FETCH : S_MEMRD);
      S_MEMWB:  retire = 1'b1;
      S_MEMWR: begin
        state_next = (mem_ready || timeout) ? S_FETCH : S_MEMWR;
        retire     = mem_ready;
      end
      S_EXEC:   state_next = S_RWB;
      S_RWB, S_BRANCH, S_JUMP: retire = 1'b1;
`ifdef MCC_IMM_EN
      S_IMMEX:  state_next = S_IMMWB;
      S_IMMWB:  retire = 1'b1;
`endif
      default:  state_next = S_FETCH;
    endcase

    // A timeout re-entry into FETCH counts as a fresh entry, so the counter restarts.
    if ((state_next != state_reg) || timeout)
      wait_cnt_next = '0;
    else if (waiting && !mem_ready)
      wait_cnt_next = wait_cnt_reg + WC_W'(1);
    else
      wait_cnt_next = wait_cnt_reg;
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUop       = 2'b00;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;
    mem_timeout = timeout;
    case (state_reg)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef MCC_IMM_EN
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUop   = (op_q_reg == OP_ANDI) ? 2'b11 : 2'b00;
      end
      S_IMMWB: RegWrite = 1'b1;
`endif
      S_ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
    // Reset aborts the instruction: no write or pulse may escape this cycle.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      illegal_op  = 1'b0;
      mem_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= '0;
      op_q_reg     <= '0;
      retired_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_reg == S_DECODE)
        op_q_reg <= opcode;
      if (retire)
        retired_reg <= retired_reg + CNT_W'(1);
    end
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback across cycles, and drives the 2-bit ALUop consumed by the ALU control decoder. It stalls on a memory ready handshake, counts retired instructions and flags illegal opcodes and memory timeouts.

Parameters:
CNT_W, 32, width of retired-instruction counter
MEM_TIMEOUT, 16, max cycles to wait for mem_ready in any memory state (minimum 1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
opcode  input  6  instr[31:26] from instruction register
mem_ready  input  1  memory completes the current access this cycle
PCWrite  output  1  unconditional PC write
PCWriteCond  output  1  PC write if ALU zero
IorD  output  1  0=PC address, 1=ALUOut address
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
MemtoReg  output  1  writeback source, 1=MDR
RegDst  output  1  1=rd, 0=rt
RegWrite  output  1  register file write
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
ALUop  output  2  to ALU control decoder
PCSource  output  2  00=ALU, 01=ALUOut, 10=jump target
state  output  4  current state encoding
illegal_op  output  1  one-cycle pulse in ILLEGAL
mem_timeout  output  1  one-cycle pulse on timeout abort
instr_retired  output  CNT_W  retired instruction count

Behaviour:
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IMMEX=10, IMMWB=11, ILLEGAL=12. Codes 13-15 go to FETCH on the next edge with all strobes 0.
- Reset: at a clock edge with reset=1, state<=FETCH, instr_retired<=0, wait counter<=0, op_q<=0. While reset=1, all of PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, illegal_op and mem_timeout are forced 0 combinationally. Reset in any state aborts the instruction with no writes.
- Outputs are Moore-decoded from state. Any signal not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00. PCWrite=IRWrite=mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00. Latches opcode into op_q. Next state by opcode: 100011/101011 to MEMADR, 000000 to EXEC, 000100 to BRANCH, 000010 to JUMP, anything else to ILLEGAL.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=00. Goes to MEMRD if op_q=lw, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Goes to FETCH on mem_ready.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10. Goes to RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- ILLEGAL: illegal_op=1, no writes. Goes to FETCH. Does not count as retired.
- Wait counter: clears on entry to FETCH, MEMRD or MEMWR, and increments each cycle that state is waiting with mem_ready=0. When the counter equals MEM_TIMEOUT-1 and mem_ready=0, mem_timeout=1 that cycle and the next state is FETCH. That cycle has no IRWrite or PCWrite, and the instruction is not retired. If mem_ready=1 and the timeout condition coincide, mem_ready wins.
- instr_retired: increments by 1 at the edge leaving MEMWB, RWB, BRANCH, JUMP or IMMWB, or leaving MEMWR with mem_ready=1. Wraps modulo 2^CNT_W.
- Cycle counts with mem_ready always 1: lw=5, sw=4, R-type=4, beq=3, j=3, illegal=3.

Optional Feature:
Macro MCC_IMM_EN.
- Defined: DECODE sends 001000 (addi) and 001100 (andi) to IMMEX. IMMEX drives ALUSrcA=1, ALUSrcB=10, and ALUop=00 for addi or 11 for andi, then goes to IMMWB. IMMWB drives RegWrite=1, RegDst=0, MemtoReg=0, then goes to FETCH and retires the instruction (4 cycles).
- Undefined: both opcodes go to ILLEGAL, and states 10/11 behave as unused codes.

Test Plan:
- reset held 2 cycles, then lw (100011) with mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; instr_retired=1.
- R-type (000000) -> ALUop=10 in EXEC, RegWrite=1 and RegDst=1 in RWB; beq (000100) -> ALUop=01 with PCWriteCond=1 for exactly 1 cycle; instr_retired=2.
- sw with mem_ready low 3 cycles in MEMWR -> MemWrite held for 4 cycles, single retire, no RegWrite.
- MEM_TIMEOUT=4 with mem_ready stuck 0 in FETCH -> mem_timeout pulses on the 4th cycle, state returns to 0, IRWrite never 1, count unchanged.
- opcode 111111 -> states 0,1,12,0; illegal_op pulse of 1 cycle; no write strobes; count unchanged.
- reset asserted in MEMWB -> RegWrite=0 that cycle, state=0 next cycle, instr_retired=0; with MCC_IMM_EN, andi (001100) -> ALUop=11 in IMMEX.
